// File: rtl/protocol_readbyte.sv
//------------------------------------------------------------------------------
// Module   : protocol_readbyte
// Brief    : I2C controller read of one byte, followed by the controller's
//            ACK/NACK on the 9th clock. SCL is generated by counting the
//            reference clock. SDA is sampled MSB-first at the middle of each
//            SCL high phase.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   CLK_CYCLES    : reference cycles per half SCL period (2..1023, even)
// Ports
//   clk           : reference clock
//   reset         : asynchronous active-high reset
//   readbyte_flag : start request, sampled only in IDLE
//   ack_send      : 1 = ACK after the byte, 0 = NACK (latched on start)
//   sda_read      : SDA line value
//   scl_read      : SCL line value (clock-stretch detection only)
//   scl_en        : 0 = drive SCL low, 1 = release SCL
//   sda_en        : 0 = drive SDA low, 1 = release SDA
//   data          : received byte, updated in the DONE cycle
//   complete      : one-cycle pulse when the byte and the ACK/NACK are done
//   busy          : transfer in progress
// Build option
//   READBYTE_STRETCH_EN : when defined, honour target clock stretching in
//                         the SCL high phases
//------------------------------------------------------------------------------
`default_nettype none

module protocol_readbyte #(
    parameter int CLK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       readbyte_flag,
    input  logic       ack_send,
    input  logic       sda_read,
    input  logic       scl_read,
    output logic       scl_en,
    output logic       sda_en,
    output logic [7:0] data,
    output logic       complete,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOW      = 3'd1,
        ST_HIGH     = 3'd2,
        ST_ACK_LOW  = 3'd3,
        ST_ACK_HIGH = 3'd4,
        ST_ACK_FIN  = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic [9:0] c_phase_last = 10'(CLK_CYCLES - 1);
    localparam logic [9:0] c_sample_pt  = 10'(CLK_CYCLES / 2);
    localparam logic [9:0] c_fin_last   = 10'(CLK_CYCLES / 2 - 1);

    state_t      state_q,    state_d;
    logic [9:0]  clk_cnt_q,  clk_cnt_d;
    logic [3:0]  bit_cnt_q,  bit_cnt_d;
    logic [7:0]  shreg_q,    shreg_d;
    logic        ack_q,      ack_d;
    logic        scl_en_q,   scl_en_d;
    logic        sda_en_q,   sda_en_d;
    logic [7:0]  data_q,     data_d;
    logic        complete_q, complete_d;
    logic        busy_q,     busy_d;

    // High while a target holds SCL low at the start of a high phase; the
    // phase counter is frozen at 0 so the phase is measured from release.
    logic        w_stretch_hold;

`ifdef READBYTE_STRETCH_EN
    assign w_stretch_hold = ~scl_read && (clk_cnt_q == 10'd0);
`else
    logic        unused_scl_read;
    assign unused_scl_read = scl_read;
    assign w_stretch_hold  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clk_cnt_q  <= 10'd0;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= 8'd0;
            ack_q      <= 1'b0;
            scl_en_q   <= 1'b1;
            sda_en_q   <= 1'b1;
            data_q     <= 8'd0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ack_q      <= ack_d;
            scl_en_q   <= scl_en_d;
            sda_en_q   <= sda_en_d;
            data_q     <= data_d;
            complete_q <= complete_d;
            busy_q     <= busy_d;
        end
    end

    // Outputs are registered from the current state, so every bus-facing
    // signal lags the state by one cycle; phase lengths are unaffected.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ack_d      = ack_q;
        scl_en_d   = scl_en_q;
        sda_en_d   = sda_en_q;
        data_d     = data_q;
        complete_d = 1'b0;
        busy_d     = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (readbyte_flag) begin
                    ack_d     = ack_send;
                    bit_cnt_d = 4'd0;
                    clk_cnt_d = 10'd0;
                    state_d   = ST_LOW;
                end
            end

            ST_LOW: begin
                scl_en_d = 1'b0;
                sda_en_d = 1'b1;
                if (clk_cnt_q == c_phase_last) begin
                    clk_cnt_d = 10'd0;
                    state_d   = ST_HIGH;
                end else begin
                    clk_cnt_d = clk_cnt_q + 10'd1;
                end
            end

            ST_HIGH: begin
                scl_en_d = 1'b1;
                if (!w_stretch_hold) begin
                    if (clk_cnt_q == c_sample_pt) begin
                        shreg_d = {shreg_q[6:0], sda_read};
                    end
                    if (clk_cnt_q == c_phase_last) begin
                        clk_cnt_d = 10'd0;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = (bit_cnt_q == 4'd7) ? ST_ACK_LOW : ST_LOW;
                    end else begin
                        clk_cnt_d = clk_cnt_q + 10'd1;
                    end
                end
            end

            ST_ACK_LOW: begin
                scl_en_d = 1'b0;
                sda_en_d = ~ack_q;
                if (clk_cnt_q == c_phase_last) begin
                    clk_cnt_d = 10'd0;
                    state_d   = ST_ACK_HIGH;
                end else begin
                    clk_cnt_d = clk_cnt_q + 10'd1;
                end
            end

            ST_ACK_HIGH: begin
                scl_en_d = 1'b1;
                if (!w_stretch_hold) begin
                    if (clk_cnt_q == c_phase_last) begin
                        clk_cnt_d = 10'd0;
                        state_d   = ST_ACK_FIN;
                    end else begin
                        clk_cnt_d = clk_cnt_q + 10'd1;
                    end
                end
            end

            // Short SCL-low tail so the target sees SCL fall before the
            // controller lets go of the ACK level on SDA.
            ST_ACK_FIN: begin
                scl_en_d = 1'b0;
                if (clk_cnt_q == c_fin_last) begin
                    clk_cnt_d = 10'd0;
                    state_d   = ST_DONE;
                end else begin
                    clk_cnt_d = clk_cnt_q + 10'd1;
                end
            end

            // Both lines are left held low for the stop/restart block.
            ST_DONE: begin
                scl_en_d   = 1'b0;
                sda_en_d   = 1'b0;
                data_d     = shreg_q;
                complete_d = 1'b1;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign scl_en   = scl_en_q;
    assign sda_en   = sda_en_q;
    assign data     = data_q;
    assign complete = complete_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_protocol_readbyte.sv
//------------------------------------------------------------------------------
// Module   : tb_protocol_readbyte
// Brief    : Directed self-checking bench for protocol_readbyte with
//            CLK_CYCLES = 8. A cycle-timed target model drives SDA/SCL.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_protocol_readbyte;

    localparam int C = 8;

    logic       clk;
    logic       reset;
    logic       readbyte_flag;
    logic       ack_send;
    logic       sda_read;
    logic       scl_read;
    logic       scl_en;
    logic       sda_en;
    logic [7:0] data;
    logic       complete;
    logic       busy;

    int n_checks;
    int n_fail;

    protocol_readbyte #(
        .CLK_CYCLES(C)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .readbyte_flag(readbyte_flag),
        .ack_send     (ack_send),
        .sda_read     (sda_read),
        .scl_read     (scl_read),
        .scl_en       (scl_en),
        .sda_en       (sda_en),
        .data         (data),
        .complete     (complete),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Target SDA for effective time te (cycles after the start edge):
    // bit b occupies [2bC, 2bC+2C), low half then high half. Optional
    // glitching toggles SDA through the low half only.
    function automatic logic sda_val(input logic [7:0] tx, input bit glitch, input int te);
        int b;
        int ph;
        if (te >= 16 * C) return 1'b1;
        b  = te / (2 * C);
        ph = te % (2 * C);
        if (glitch && ph < C) return te[0];
        return tx[7 - b];
    endfunction

    // One read transaction. abort_t / pulse_t < 0 disable the reset abort
    // and the stray start pulse; stretch_len holds SCL low from the start of
    // bit 2's high phase.
    task automatic run_read(input string name, input logic [7:0] tx, input logic ack,
                            input bit glitch, input int abort_t, input int pulse_t,
                            input int stretch_len);
        int t;
        int te;
        int shift;
        int st;
        int exp_lat;
        int first_c;
        int n_c;
        bit win_bad;
        bit aborted;

        st = 5 * C;
`ifdef READBYTE_STRETCH_EN
        shift = stretch_len;
`else
        shift = 0;
`endif
        exp_lat = 18 * C + C / 2 + 1 + shift;
        first_c = -1;
        n_c     = 0;
        win_bad = 1'b0;
        aborted = 1'b0;

        readbyte_flag = 1'b1;
        ack_send      = ack;
        @(posedge clk);
        #1;
        readbyte_flag = 1'b0;
        ack_send      = ~ack;   // must have been latched already
        check_val({name, "_busy_t0"}, 32'(busy), 32'd0);

        t = 0;
        while (t < exp_lat + 3) begin
            if (t == abort_t) begin
                reset = 1'b1;
                #1;
                check_val({name, "_abort_scl_en"},   32'(scl_en),   32'd1);
                check_val({name, "_abort_sda_en"},   32'(sda_en),   32'd1);
                check_val({name, "_abort_data"},     32'(data),     32'd0);
                check_val({name, "_abort_complete"}, 32'(complete), 32'd0);
                check_val({name, "_abort_busy"},     32'(busy),     32'd0);
                @(posedge clk);
                #1;
                reset   = 1'b0;
                aborted = 1'b1;
                break;
            end
            te = (shift == 0 || t < st) ? t : ((t < st + shift) ? st : t - shift);
            sda_read      = sda_val(tx, glitch, te);
            scl_read      = !(stretch_len > 0 && t >= st && t < st + stretch_len);
            readbyte_flag = (t == pulse_t);
            @(posedge clk);
            #1;
            t++;
            te = (shift == 0 || t < st) ? t : ((t < st + shift) ? st : t - shift);
            if (t == 1) check_val({name, "_busy_t1"}, 32'(busy), 32'd1);
            if (te >= 16 * C + 1 && te <= 18 * C && sda_en !== ~ack) win_bad = 1'b1;
            if (complete === 1'b1) begin
                n_c++;
                if (first_c < 0) begin
                    first_c = t;
                    check_val({name, "_data"},        32'(data),   32'(tx));
                    check_val({name, "_done_scl_en"}, 32'(scl_en), 32'd0);
                    check_val({name, "_done_sda_en"}, 32'(sda_en), 32'd0);
                end
            end
            if (first_c >= 0 && t == first_c + 1) begin
                check_val({name, "_complete_fall"}, 32'(complete), 32'd0);
                check_val({name, "_busy_fall"},     32'(busy),     32'd0);
            end
        end

        readbyte_flag = 1'b0;
        scl_read      = 1'b1;
        sda_read      = 1'b1;
        if (!aborted) begin
            check_val({name, "_latency"},    32'(first_c), 32'(exp_lat));
            check_val({name, "_pulses"},     32'(n_c),     32'd1);
            check_val({name, "_ack_window"}, 32'(win_bad), 32'd0);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        readbyte_flag = 1'b0;
        ack_send      = 1'b0;
        sda_read      = 1'b1;
        scl_read      = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_scl_en",   32'(scl_en),   32'd1);
        check_val("rst_sda_en",   32'(sda_en),   32'd1);
        check_val("rst_data",     32'(data),     32'd0);
        check_val("rst_complete", 32'(complete), 32'd0);
        check_val("rst_busy",     32'(busy),     32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_read("ack_a5",    8'hA5, 1'b1, 1'b0, -1, -1, 0);
        run_read("nack_3c",   8'h3C, 1'b0, 1'b0, -1, -1, 0);
        run_read("glitch_ff", 8'hFF, 1'b1, 1'b1, -1, -1, 0);
        run_read("abort",     8'h66, 1'b1, 1'b0, 8 * C + 3, -1, 0);
        run_read("after_81",  8'h81, 1'b1, 1'b0, -1, -1, 0);
        run_read("pulse_c3",  8'hC3, 1'b1, 1'b0, -1, 30, 0);
        run_read("stretch",   8'h5A, 1'b1, 1'b0, -1, -1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
